pe_edge_source: RTL and testbench
=================================

PE_EDGE_SOURCE -- requirements
Module: pe_edge_source

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 3, meaning the address field width of a mesh word.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 3, meaning the data field width of a mesh word.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning the queue depth in words; it is a power of two and at least 2.
REQ-004 Port list, with W = ADDR_WIDTH+DATA_WIDTH and C = log2(DEPTH)+1:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset.
- i_wr_valid  input  1  host write request.
- i_wr_word  input  W  host word, {addr, data}, addr in the MSBs.
- o_wr_ready  output  1  queue can accept a word.
- i_step  input  1  mesh step strobe from the sort controller.
- i_flush  input  1  discard all queued and presented words.
- o_PE  output  W  registered word presented on an edge PE neighbour input (i_PE_l/r/u/d).
- o_valid  output  1  o_PE holds a real queued word.
- o_count  output  C  number of words currently queued.
- o_underrun  output  1  sticky: a step found the queue empty while running.

Function
REQ-005 The block SHALL be a source for a mesh-edge neighbour port: it queues host words and presents them to a PE, one word per step.
REQ-006 FILL SHALL be the all-ones W-bit word; it sorts last and marks "no element".
REQ-007 A write SHALL be accepted on a cycle where i_wr_valid=1, o_wr_ready=1 and i_flush=0; the word is stored at the write pointer, and the write pointer increments modulo DEPTH.
REQ-008 o_wr_ready SHALL be combinational and equal (o_count < DEPTH); a write while full is dropped with no state change.
REQ-009 The FSM SHALL have two states, IDLE and RUN, and reset to IDLE.
REQ-010 On i_step=1 with o_count>0, the block SHALL on that edge:
- load the head word into o_PE;
- set o_valid=1;
- increment the read pointer modulo DEPTH;
- move the FSM to RUN (or stay in RUN).
REQ-011 On i_step=1 with o_count=0, the block SHALL load o_PE with FILL and clear o_valid; in RUN it also sets o_underrun=1, and in IDLE o_underrun is unchanged.
REQ-012 With i_step=0, o_PE and o_valid SHALL hold their values.
REQ-013 There SHALL be no write-to-read bypass: a word written on edge N is first visible on o_PE at the edge of a step sampled at edge N+1 or later.
REQ-014 A simultaneous accepted write and non-empty step SHALL leave o_count unchanged; a write alone adds 1, and a pop alone subtracts 1.
REQ-015 A write while full combined with a step SHALL be dropped, because o_wr_ready reflects pre-edge occupancy.
REQ-016 When i_flush=1, flush SHALL dominate write and step, and the block SHALL:
- zero both pointers and o_count;
- set o_PE=FILL and o_valid=0;
- clear o_underrun;
- set the FSM to IDLE.
REQ-017 o_count SHALL be registered and never exceed DEPTH.
REQ-018 The pointers SHALL be log2(DEPTH) bits wide and wrap naturally; full and empty are distinguished via o_count.
REQ-019 Queue storage SHALL need no reset; only pointers, count, outputs and the FSM are reset.

Reset
REQ-020 While rst=0 at a rising edge, the block SHALL set o_PE=FILL, o_valid=0, o_count=0, o_underrun=0, both pointers to 0, and the FSM to IDLE; o_wr_ready then reads 1.
REQ-021 Reset SHALL override flush, write and step in the same cycle; words queued before a mid-operation reset are lost.

Verification
REQ-022 Reset check: hold rst=0 for 2 cycles, then release -> o_PE=6'b111_111, o_valid=0, o_count=0, o_wr_ready=1, o_underrun=0.
REQ-023 Ordering: write 6'b000_011, 6'b001_010 and 6'b010_001 on consecutive cycles, then 3 steps -> o_PE shows 000_011, then 001_010, then 010_001, with o_valid=1 and o_count going 3, 2, 1, 0.
REQ-024 Full and wrap-around:
- write 9 words -> the 9th is dropped, o_count=8, o_wr_ready=0;
- then alternate one step and one write for 12 cycles -> output order is preserved across the pointer wrap.
REQ-025 Underrun:
- step once with the queue empty in IDLE -> o_PE=FILL, o_underrun=0;
- queue 1 word, then step twice -> o_PE shows the word then FILL, and o_underrun=1 stays set until flush.
REQ-026 Simultaneous events:
- with 4 words queued, assert i_flush together with i_wr_valid and i_step -> o_count=0, o_PE=FILL, FSM in IDLE;
- repeat with rst=0 instead of i_flush -> same result.

Source files
------------

// File: rtl/pe_edge_source.sv
// Mesh-edge word source: queues host words and presents one per step on a
// registered PE neighbour input, padding with the all-ones FILL word when dry.
module pe_edge_source #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_wr_valid,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_wr_word,
  output logic                            o_wr_ready,
  input  logic                            i_step,
  input  logic                            i_flush,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE,
  output logic                            o_valid,
  output logic [$clog2(DEPTH):0]          o_count,
  output logic                            o_underrun
);

  localparam int W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int C  = PW + 1;
  localparam logic [W-1:0] FILL    = '1;
  localparam logic [C-1:0] DEPTH_C = C'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [C-1:0]  count_reg;
  logic [C-1:0]  count_next;
  logic [W-1:0]  pe_reg;
  logic          valid_reg;
  logic          underrun_reg;
  state_t        state_reg;

  logic wr_en;
  logic rd_en;
  logic not_empty;

  assign not_empty  = (count_reg != '0);
  // Ready reflects pre-edge occupancy, so a write while full is dropped even
  // if a pop happens on the same edge.
  assign o_wr_ready = (count_reg < DEPTH_C);
  assign wr_en      = i_wr_valid & o_wr_ready & ~i_flush;
  assign rd_en      = i_step & not_empty & ~i_flush;

  always_comb begin
    count_next = count_reg;
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem[wr_ptr_reg] <= i_wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      pe_reg       <= FILL;
      valid_reg    <= 1'b0;
      underrun_reg <= 1'b0;
      state_reg    <= IDLE;
    end else if (i_flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      pe_reg       <= FILL;
      valid_reg    <= 1'b0;
      underrun_reg <= 1'b0;
      state_reg    <= IDLE;
    end else begin
      count_reg <= count_next;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (i_step) begin
        if (rd_en) begin
          pe_reg     <= mem[rd_ptr_reg];
          valid_reg  <= 1'b1;
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
          state_reg  <= RUN;
        end else begin
          // A dry step before the first real word is just priming, not underrun.
          pe_reg    <= FILL;
          valid_reg <= 1'b0;
          if (state_reg == RUN) begin
            underrun_reg <= 1'b1;
          end
        end
      end
    end
  end

  assign o_PE       = pe_reg;
  assign o_valid    = valid_reg;
  assign o_count    = count_reg;
  assign o_underrun = underrun_reg;

endmodule

// File: tb/tb_pe_edge_source.sv
// Bench for pe_edge_source: directed scenarios plus random traffic checked
// against a queue-based reference model.
module tb_pe_edge_source;

  localparam int AW = 3;
  localparam int DW = 3;
  localparam int DEPTH = 8;
  localparam int W = AW + DW;
  localparam int C = $clog2(DEPTH) + 1;
  localparam int VW = W + C + 3;
  localparam logic [W-1:0] FILL = '1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_valid = 1'b0;
  logic [W-1:0] wr_word = '0;
  logic wr_ready;
  logic step = 1'b0;
  logic flush = 1'b0;
  logic [W-1:0] pe;
  logic valid;
  logic [C-1:0] count;
  logic underrun;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] m_pe = FILL;
  logic m_valid = 1'b0;
  logic m_under = 1'b0;
  logic m_running = 1'b0;

  pe_edge_source #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_wr_valid(wr_valid), .i_wr_word(wr_word),
    .o_wr_ready(wr_ready), .i_step(step), .i_flush(flush), .o_PE(pe),
    .o_valid(valid), .o_count(count), .o_underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] act_vec();
    return {pe, valid, count, wr_ready, underrun};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [C-1:0] n;
    n = C'(q.size());
    return {m_pe, m_valid, n, (q.size() < DEPTH), m_under};
  endfunction

  // Model: the queue is a FIFO of words; a step pops the head if there is one,
  // and the "running" flag records that a real word has been presented since
  // the last reset/flush.
  task automatic model_edge(input logic wv, input logic [W-1:0] w,
                            input logic st, input logic fl, input logic rs);
    bit room;
    if (!rs || fl) begin
      q.delete();
      m_pe = FILL; m_valid = 1'b0; m_under = 1'b0; m_running = 1'b0;
    end else begin
      room = (q.size() < DEPTH);
      if (st) begin
        if (q.size() > 0) begin
          m_pe = q.pop_front(); m_valid = 1'b1; m_running = 1'b1;
        end else begin
          m_pe = FILL; m_valid = 1'b0;
          if (m_running) m_under = 1'b1;
        end
      end
      if (wv && room) q.push_back(w);
    end
  endtask

  task automatic tick(input logic wv, input logic [W-1:0] w,
                      input logic st, input logic fl, input logic rs);
    wr_valid = wv; wr_word = w; step = st; flush = fl; rst = rs;
    @(posedge clk);
    model_edge(wv, w, st, fl, rs);
    @(negedge clk);
    wr_valid = 1'b0; step = 1'b0; flush = 1'b0; rst = 1'b1;
    $display("txn wv=%b w=%h st=%b fl=%b rst=%b -> pe=%h v=%b cnt=%0d rdy=%b und=%b",
             wv, w, st, fl, rs, pe, valid, count, wr_ready, underrun);
  endtask

  task automatic test_reset();
    logic [VW-1:0] lit;
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    lit = {6'b111_111, 1'b0, 4'd0, 1'b1, 1'b0};
    n_cmp++;
    if (act_vec() !== lit) begin
      n_mis++; $display("FAIL reset_literal: got %h want %h", act_vec(), lit);
    end
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_mis++; $display("FAIL reset_model: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_ordering();
    logic [W-1:0] words [3];
    logic [C-1:0] cnt_exp;
    words[0] = 6'b000_011; words[1] = 6'b001_010; words[2] = 6'b010_001;
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, words[i], 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (count !== 4'd3) begin
      n_mis++; $display("FAIL order_count_loaded: got %0d want 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
      cnt_exp = C'(2 - i);
      n_cmp++;
      if (pe !== words[i] || valid !== 1'b1 || count !== cnt_exp) begin
        n_mis++;
        $display("FAIL order_step%0d: got pe=%h v=%b cnt=%0d want pe=%h v=1 cnt=%0d",
                 i, pe, valid, count, words[i], cnt_exp);
      end
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_mis++; $display("FAIL order_model%0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_full_wrap();
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, W'($urandom), 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_mis++; $display("FAIL fill_write%0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (count !== 4'd8 || wr_ready !== 1'b0) begin
      n_mis++; $display("FAIL full_state: got cnt=%0d rdy=%b want cnt=8 rdy=0", count, wr_ready);
    end
    // full + step + write: write must be dropped
    tick(1'b1, W'($urandom), 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (act_vec() !== exp_vec() || count !== 4'd7) begin
      n_mis++; $display("FAIL full_step_write: got %h want %h", act_vec(), exp_vec());
    end
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
      else            tick(1'b1, W'($urandom), 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_mis++; $display("FAIL wrap_cycle%0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_underrun();
    logic [W-1:0] w;
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (pe !== FILL || underrun !== 1'b0 || valid !== 1'b0) begin
      n_mis++; $display("FAIL idle_empty_step: got pe=%h und=%b v=%b want pe=%h und=0 v=0", pe, underrun, valid, FILL);
    end
    w = W'($urandom_range(0, 62));
    tick(1'b1, w, 1'b0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (pe !== w || valid !== 1'b1 || underrun !== 1'b0) begin
      n_mis++; $display("FAIL under_word: got pe=%h v=%b und=%b want pe=%h v=1 und=0", pe, valid, underrun, w);
    end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (pe !== FILL || valid !== 1'b0 || underrun !== 1'b1) begin
      n_mis++; $display("FAIL under_set: got pe=%h v=%b und=%b want pe=%h v=0 und=1", pe, valid, underrun, FILL);
    end
    tick(1'b1, W'($urandom), 1'b0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (underrun !== 1'b1 || act_vec() !== exp_vec()) begin
      n_mis++; $display("FAIL under_sticky: got %h want %h", act_vec(), exp_vec());
    end
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (underrun !== 1'b0 || act_vec() !== exp_vec()) begin
      n_mis++; $display("FAIL under_flush_clear: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) tick(1'b1, W'($urandom), 1'b0, 1'b0, 1'b1);
      tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
      tick(1'b1, W'($urandom), 1'b0, 1'b0, 1'b1);
      if (k == 0) tick(1'b1, W'($urandom), 1'b1, 1'b1, 1'b1);
      else        tick(1'b1, W'($urandom), 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (count !== 4'd0 || pe !== FILL || valid !== 1'b0 || underrun !== 1'b0) begin
        n_mis++; $display("FAIL simul%0d_clear: got pe=%h v=%b cnt=%0d und=%b", k, pe, valid, count, underrun);
      end
      // an empty step right after must not flag underrun: FSM is back in IDLE
      tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (underrun !== 1'b0 || act_vec() !== exp_vec()) begin
        n_mis++; $display("FAIL simul%0d_idle: got %h want %h", k, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic wv, st, fl, rs;
    for (int i = 0; i < 400; i++) begin
      wv = ($urandom_range(0, 99) < 55);
      st = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 59) != 0);
      tick(wv, W'($urandom), st, fl, rs);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_mis++; $display("FAIL random%0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ordering();
    test_full_wrap();
    test_underrun();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
